// File: rtl/arbiter_pkg.sv
// Shared definitions for the two-port RAM arbiter: FSM encoding and port indices.
package arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  localparam int unsigned CNT_W = 3;

endpackage

// File: rtl/rr_grant.sv
// Two-way round-robin select: a lone request wins, a tie goes to the port that did not win last.
module rr_grant
  import arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant,
  output logic       any_valid
);

  always_comb begin
    any_valid = |valid;
    grant     = PORT_CPU;
    if (valid[0] && valid[1]) begin
      grant = ~last_grant;
    end else if (valid[1]) begin
      grant = PORT_DBG;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates a CPU port and a debug/loader port onto one fixed-latency RAM.
// All outputs are registered; next values come from the FSM's combinational process.
module ram_arbiter
  import arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned RAM_LATENCY = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  p0_valid,
  input  logic                  p0_write,
  input  logic [ADDR_WIDTH-1:0] p0_address,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_done,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  input  logic                  p1_valid,
  input  logic                  p1_write,
  input  logic [ADDR_WIDTH-1:0] p1_address,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_done,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic                  ram_enable,
  output logic                  ram_write,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             grant_q, grant_d;
  logic             last_grant_q, last_grant_d;
  logic             write_q, write_d;

  logic                  enable_d, ram_write_d;
  logic [ADDR_WIDTH-1:0] address_d;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic                  p0_done_d, p1_done_d;
  logic [DATA_WIDTH-1:0] p0_rdata_d, p1_rdata_d;

  logic sel;
  logic any_valid;

  rr_grant u_rr_grant (
    .valid      ({p1_valid, p0_valid}),
    .last_grant (last_grant_q),
    .grant      (sel),
    .any_valid  (any_valid)
  );

  // Next-state and next-output logic; ram_address/ram_wdata double as the latched request fields.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    write_d      = write_q;
    address_d    = ram_address;
    wdata_d      = ram_wdata;
    enable_d     = 1'b0;
    ram_write_d  = 1'b0;
    p0_done_d    = 1'b0;
    p1_done_d    = 1'b0;
    p0_rdata_d   = p0_rdata;
    p1_rdata_d   = p1_rdata;

    case (state_q)
      IDLE: begin
        if (any_valid) begin
          grant_d     = sel;
          write_d     = (sel == PORT_DBG) ? p1_write   : p0_write;
          address_d   = (sel == PORT_DBG) ? p1_address : p0_address;
          wdata_d     = (sel == PORT_DBG) ? p1_wdata   : p0_wdata;
          cnt_d       = CNT_W'(RAM_LATENCY);
          enable_d    = 1'b1;
          ram_write_d = write_d;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          // Last held cycle: read data is valid now.
          if (!write_q) begin
            if (grant_q == PORT_DBG) p1_rdata_d = ram_rdata;
            else                     p0_rdata_d = ram_rdata;
          end
          p0_done_d = (grant_q == PORT_CPU);
          p1_done_d = (grant_q == PORT_DBG);
          state_d   = DONE;
        end else begin
          enable_d    = 1'b1;
          ram_write_d = write_q;
        end
      end
      DONE: begin
        last_grant_d = grant_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      grant_q      <= PORT_CPU;
      last_grant_q <= PORT_DBG;
      write_q      <= 1'b0;
      ram_enable   <= 1'b0;
      ram_write    <= 1'b0;
      ram_address  <= '0;
      ram_wdata    <= '0;
      p0_done      <= 1'b0;
      p1_done      <= 1'b0;
      p0_rdata     <= '0;
      p1_rdata     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      write_q      <= write_d;
      ram_enable   <= enable_d;
      ram_write    <= ram_write_d;
      ram_address  <= address_d;
      ram_wdata    <= wdata_d;
      p0_done      <= p0_done_d;
      p1_done      <= p1_done_d;
      p0_rdata     <= p0_rdata_d;
      p1_rdata     <= p1_rdata_d;
    end
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 8: RAM word-address width.
REQ-002 Parameter DATA_WIDTH, default 32: RAM data width.
REQ-003 Parameter RAM_LATENCY, default 2, legal 1..7: cycles ram_enable is held per access; read data is valid in the last held cycle.
REQ-004 clock  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-low reset (0 = reset), sampled on rising clock edge.
REQ-006 p0_valid / p1_valid  in  1  requester 0 (CPU memory stage) / requester 1 (debug/loader) transaction request.
REQ-007 pN_write  in  1  1 = write, 0 = read.
REQ-008 pN_address  in  ADDR_WIDTH  word address.
REQ-009 pN_wdata  in  DATA_WIDTH  write data.
REQ-010 pN_done  out  1  one-cycle completion pulse.
REQ-011 pN_rdata  out  DATA_WIDTH  read data; held until that port's next completion.
REQ-012 ram_enable, ram_write  out  1  RAM strobe and direction.
REQ-013 ram_address  out  ADDR_WIDTH; ram_wdata  out  DATA_WIDTH; ram_rdata  in  DATA_WIDTH.

Function
REQ-014 FSM states: IDLE, ACCESS, DONE; exactly one state active.
REQ-015 IDLE: no valid -> stay IDLE; any valid -> grant one port, latch its write/address/wdata, load counter = RAM_LATENCY, go ACCESS.
REQ-016 Arbitration: one valid -> grant it; both valid -> grant port not equal to last_grant (round-robin).
REQ-017 ACCESS: ram_enable=1, ram_write/ram_address/ram_wdata from latched fields; counter decrements each cycle; at counter==1 capture ram_rdata (reads only) into granted port's rdata register, go DONE.
REQ-018 DONE: granted pN_done=1 for exactly this cycle; last_grant := granted port; go IDLE.
REQ-019 Latency: valid first seen in IDLE cycle N -> ram_enable high cycles N+1..N+RAM_LATENCY -> done in cycle N+RAM_LATENCY+1.
REQ-020 Writes follow identical timing; pN_rdata unchanged by writes.
REQ-021 Outside ACCESS: ram_enable=0, ram_write=0; ram_address/ram_wdata hold last value.
REQ-022 Requester holds valid and fields stable until done; changes during ACCESS ignored (latched copy used).
REQ-023 Valid dropped before grant is not served; valid still high in cycle after done is a new transaction.
REQ-024 Non-granted valid waits in IDLE; with both asserting continuously, grants alternate 0,1,0,1; no port waits more than one other transaction.
REQ-025 At most one pN_done high in any cycle; never both.

Reset
REQ-026 reset==0 at a clock edge: state := IDLE, counter := 0, last_grant := 1 (port 0 wins first tie), p0_rdata/p1_rdata := 0, ram_address/ram_wdata := 0.
REQ-027 During and after reset: ram_enable=0, ram_write=0, p0_done=p1_done=0.
REQ-028 Reset mid-ACCESS or in DONE aborts the transaction with no done pulse; requester must reissue.

Structure
REQ-029 State encoding (IDLE/ACCESS/DONE) and port indices (PORT_CPU=0, PORT_DBG=1) in shared package arbiter_pkg.
REQ-030 One sub-module: rr_grant (2-way round-robin select, combinational, inputs valids + last_grant, output grant index + any_valid).

Verification
REQ-031 Reset: hold reset=0 for 3 cycles with both valid=1 -> ram_enable=0, done=0, rdata=0 throughout.
REQ-032 Single read: RAM_LATENCY=2, p0 read addr 0x05 with RAM returning 0xDEADBEEF -> ram_enable 2 cycles, p0_done at N+3, p0_rdata=0xDEADBEEF.
REQ-033 Write: p1 write addr 0x10 data 0x12345678 -> ram_write=1 with those values for 2 cycles, p1_done at N+3, p1_rdata unchanged.
REQ-034 Contention: both valid from reset release, each 4 transactions -> grant order 0,1,0,1,0,1,0,1; never simultaneous done.
REQ-035 Abort: reset=0 during second ACCESS cycle -> no done, next cycle IDLE, ram_enable=0.
REQ-036 Stability: p0 changes address 0x05->0x06 mid-ACCESS -> ram_address stays 0x05 until done.
